bram_tdp_be_clr: RTL

BRAM_TDP_BE_CLR -- requirements
Module: bram_tdp_be_clr

---
 rtl/bram_tdp_be_clr.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bram_tdp_be_clr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_tdp_be_clr : true dual-port byte-enable RAM, self-clears after reset |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module bram_tdp_be_clr #(
  parameter int                    ADDR_WIDTH   = 9,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    CHUNKSIZE    = 8,
  parameter int                    WE_WIDTH     = 4,
  parameter int                    MEMSIZE      = 512,
  parameter int                    READ_LATENCY = 1,
  parameter int                    WRITE_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic [WE_WIDTH-1:0]   WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [WE_WIDTH-1:0]   WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID,
  output logic                  READY,
  output logic                  COLLISION
);

  localparam int                  IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEMSIZE);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(MEMSIZE - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic collision_q, collision_d;

  logic [DATA_WIDTH-1:0] mem_q [MEMSIZE];

  logic                  ready_w, clear_we;
  logic                  acc_a, acc_b, in_range_a, in_range_b;
  logic [IDX_W-1:0]      idx_a, idx_b;
  logic [WE_WIDTH-1:0]   we_a, we_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  logic [READ_LATENCY-1:0]                 pa_vld_q, pa_vld_d, pb_vld_q, pb_vld_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pa_data_q, pa_data_d, pb_data_q, pb_data_d;

  assign ready_w    = (state_q == ST_RUN);
  assign clear_we   = (state_q == ST_CLEAR) && !RST;
  assign acc_a      = ENA && ready_w;
  assign acc_b      = ENB && ready_w;
  assign in_range_a = {1'b0, ADDRA} < MEM_LIMIT;
  assign in_range_b = {1'b0, ADDRB} < MEM_LIMIT;
  assign idx_a      = ADDRA[IDX_W-1:0];
  assign idx_b      = ADDRB[IDX_W-1:0];
  // Out-of-range writes vanish here, so they can never alias onto a real word.
  assign we_a       = (acc_a && in_range_a) ? WEA : '0;
  assign we_b       = (acc_b && in_range_b) ? WEB : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign collision_d = (idx_a == idx_b) && (|(we_a & we_b));

  // Both ports see the array before this cycle's writes; only the same-port
  // write-first mode substitutes the incoming lanes.
  always_comb begin
    rdata_a = in_range_a ? mem_q[idx_a] : '0;
    rdata_b = in_range_b ? mem_q[idx_b] : '0;
    if (WRITE_MODE == 0) begin
      for (int j = 0; j < WE_WIDTH; j++) begin
        if (we_a[j]) rdata_a[j*CHUNKSIZE +: CHUNKSIZE] = DIA[j*CHUNKSIZE +: CHUNKSIZE];
        if (we_b[j]) rdata_b[j*CHUNKSIZE +: CHUNKSIZE] = DIB[j*CHUNKSIZE +: CHUNKSIZE];
      end
    end
  end

  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_pipe
    if (i == 0) begin : g_head
      assign pa_vld_d[i]  = acc_a;
      assign pb_vld_d[i]  = acc_b;
      assign pa_data_d[i] = acc_a ? rdata_a : pa_data_q[i];
      assign pb_data_d[i] = acc_b ? rdata_b : pb_data_q[i];
    end else begin : g_tail
      assign pa_vld_d[i]  = pa_vld_q[i-1];
      assign pb_vld_d[i]  = pb_vld_q[i-1];
      assign pa_data_d[i] = pa_vld_q[i-1] ? pa_data_q[i-1] : pa_data_q[i];
      assign pb_data_d[i] = pb_vld_q[i-1] ? pb_data_q[i-1] : pb_data_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      collision_q <= 1'b0;
      pa_vld_q    <= '0;
      pb_vld_q    <= '0;
      pa_data_q   <= '0;
      pb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      collision_q <= collision_d;
      pa_vld_q    <= pa_vld_d;
      pb_vld_q    <= pb_vld_d;
      pa_data_q   <= pa_data_d;
      pb_data_q   <= pb_data_d;
    end
  end

  // Port A is applied last so it owns any lane both ports write.
  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem_q[clr_cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int j = 0; j < WE_WIDTH; j++) begin
        if (we_b[j]) mem_q[idx_b][j*CHUNKSIZE +: CHUNKSIZE] <= DIB[j*CHUNKSIZE +: CHUNKSIZE];
      end
      for (int j = 0; j < WE_WIDTH; j++) begin
        if (we_a[j]) mem_q[idx_a][j*CHUNKSIZE +: CHUNKSIZE] <= DIA[j*CHUNKSIZE +: CHUNKSIZE];
      end
    end
  end

  assign DOA       = pa_data_q[READ_LATENCY-1];
  assign DOB       = pb_data_q[READ_LATENCY-1];
  assign DOA_VALID = pa_vld_q[READ_LATENCY-1];
  assign DOB_VALID = pb_vld_q[READ_LATENCY-1];
  assign READY     = ready_w;
  assign COLLISION = collision_q;

endmodule
`default_nettype wire
